// File: rtl/vehicle_motion_controller_if.sv
// Bus between the display/game logic and the vehicle motion controller.
// Protocol: the controller watches i_VGA_VSync (active low). A sweep starts on a
// qualified falling edge. o_Busy is high while the sweep runs, one cycle per car.
// o_Frame_Done then pulses for one cycle, and at that point every o_Car_X lane
// holds its new value. The inputs need no acknowledge. i_Speed_Level is sampled
// only when a sweep starts.
interface vehicle_motion_controller_if #(
    parameter int NUM_CARS = 4
);
    logic                    i_VGA_VSync;
    logic                    i_Enable;
    logic [1:0]              i_Speed_Level;
    logic [10*NUM_CARS-1:0]  o_Car_X;
    logic [10*NUM_CARS-1:0]  o_Car_Y;
    logic                    o_Busy;
    logic                    o_Frame_Done;
    logic [1:0]              o_Dbg_State;

    modport master (
        output i_VGA_VSync, i_Enable, i_Speed_Level,
        input  o_Car_X, o_Car_Y, o_Busy, o_Frame_Done, o_Dbg_State
    );

    modport slave (
        input  i_VGA_VSync, i_Enable, i_Speed_Level,
        output o_Car_X, o_Car_Y, o_Busy, o_Frame_Done, o_Dbg_State
    );
endinterface

// File: rtl/vehicle_motion_controller.sv
// Per-frame motion scheduler for the lane vehicles.
// After every FRAME_DIV-th VSync falling edge, one shared adder/subtractor visits
// the cars, one car per clock. Even lanes move right and odd lanes move left.
// Both directions wrap at the screen edges.
module vehicle_motion_controller #(
    parameter int NUM_CARS       = 4,
    parameter int H_VISIBLE_AREA = 640,
    parameter int TILE_SIZE      = 32,
    parameter int FRAME_DIV      = 2,
    parameter int BASE_SPEED     = 2,
    parameter int LANE_Y0        = 64,
    parameter int LANE_PITCH     = 64
) (
    input  logic                           i_Clk,
    input  logic                           i_Reset,
    vehicle_motion_controller_if.slave     bus
);
    localparam int              MAX_X    = H_VISIBLE_AREA - TILE_SIZE;
    localparam int              SPACING  = H_VISIBLE_AREA / NUM_CARS;
    localparam int              FC_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [2:0]      LAST_IDX = 3'(NUM_CARS - 1);
    localparam logic [FC_W-1:0] LAST_FC  = FC_W'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_vs_d;
    logic [FC_W-1:0] r_frame_cnt;
    logic [2:0]      r_idx;
    logic [9:0]      r_step;
    logic [9:0]      r_car_x [NUM_CARS];

    logic            w_fall;
    logic            w_start;
    logic [9:0]      w_cur_x;
    logic [10:0]     w_sum;
    logic [9:0]      w_new_x;

    assign w_fall  = r_vs_d && !bus.i_VGA_VSync;
    // Edges seen outside IDLE are neither counted nor allowed to start a sweep.
    assign w_start = w_fall && (r_state == ST_IDLE) && bus.i_Enable &&
                     (r_frame_cnt == LAST_FC);

    // VSync history and the frame divider; the divider is held at 0 while frozen.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_vs_d      <= 1'b1;
            r_frame_cnt <= '0;
        end else begin
            r_vs_d <= bus.i_VGA_VSync;
            if (!bus.i_Enable) begin
                r_frame_cnt <= '0;
            end else if (w_fall && (r_state == ST_IDLE)) begin
                if (r_frame_cnt == LAST_FC) begin
                    r_frame_cnt <= '0;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FC_W'(1);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: IDLE -> SWEEP on a qualified edge, SWEEP for NUM_CARS cycles, one DONE cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_next = ST_SWEEP;
            ST_SWEEP: if (r_idx == LAST_IDX) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Car index and the step size; the step is frozen for the whole sweep.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_idx  <= '0;
            r_step <= '0;
        end else if (w_start) begin
            r_idx  <= '0;
            r_step <= 10'(BASE_SPEED) + {8'd0, bus.i_Speed_Level};
        end else if (r_state == ST_SWEEP) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    // Shared add/sub unit. It selects the current car, then applies the lane direction and the wrap.
    always_comb begin
        w_cur_x = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (r_idx == 3'(i)) w_cur_x = r_car_x[i];
        end
        // The 11-bit sum keeps X + step from overflowing before the compare.
        w_sum   = {1'b0, w_cur_x} + {1'b0, r_step};
        w_new_x = w_cur_x;
        if (!r_idx[0]) begin
            w_new_x = (w_sum > 11'(MAX_X)) ? 10'd0 : w_sum[9:0];
        end else begin
            w_new_x = (w_cur_x < r_step) ? 10'(MAX_X) : (w_cur_x - r_step);
        end
    end

    // Position registers. Reset spreads the cars evenly; a reset mid-sweep restores these values.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            for (int i = 0; i < NUM_CARS; i++) begin
                r_car_x[i] <= 10'(i * SPACING);
            end
        end else if (r_state == ST_SWEEP) begin
            for (int i = 0; i < NUM_CARS; i++) begin
                if (r_idx == 3'(i)) r_car_x[i] <= w_new_x;
            end
        end
    end

    assign bus.o_Busy       = (r_state == ST_SWEEP);
    assign bus.o_Frame_Done = (r_state == ST_DONE);
    assign bus.o_Dbg_State  = r_state;

    for (genvar g = 0; g < NUM_CARS; g++) begin : g_car_out
        assign bus.o_Car_X[10*g +: 10] = r_car_x[g];
        assign bus.o_Car_Y[10*g +: 10] = 10'(LANE_Y0 + g * LANE_PITCH);
    end
endmodule

// File: tb/tb_vehicle_motion_controller.sv
// Testbench for vehicle_motion_controller. Stimulus pushes the expected car
// positions for each sweep it triggers. A separate monitor pops one entry on every
// o_Frame_Done pulse and also checks how long each busy window lasts.
module tb_vehicle_motion_controller;
    localparam int NUM_CARS = 4;
    localparam int W        = 10 * NUM_CARS;
    localparam int MAX_X    = 608;
    localparam logic [W-1:0] RESET_X = {10'd480, 10'd320, 10'd160, 10'd0};
    localparam logic [W-1:0] RESET_Y = {10'd256, 10'd192, 10'd128, 10'd64};
    localparam logic [W-1:0] SWEEP1_X = {10'd477, 10'd323, 10'd157, 10'd3};

    logic clk = 1'b0;
    logic rst;

    // Clock and reset
    always #5 clk = ~clk;

    vehicle_motion_controller_if #(.NUM_CARS(NUM_CARS)) bus();

    vehicle_motion_controller #(.NUM_CARS(NUM_CARS)) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    int m_x [NUM_CARS];
    int m_cnt = 0;
    int done_count = 0;
    int busy_total = 0;
    int busy_run = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int car_x(input int i);
        return int'(bus.o_Car_X[10*i +: 10]);
    endfunction

    // Reference model of the car positions
    task automatic model_reset();
        for (int i = 0; i < NUM_CARS; i++) m_x[i] = i * 160;
        m_cnt = 0;
    endtask

    task automatic model_step(input int step);
        for (int i = 0; i < NUM_CARS; i++) begin
            if (i % 2 == 0) begin
                if (m_x[i] + step > MAX_X) m_x[i] = 0;
                else m_x[i] = m_x[i] + step;
            end else begin
                if (m_x[i] < step) m_x[i] = MAX_X;
                else m_x[i] = m_x[i] - step;
            end
        end
    endtask

    function automatic logic [W-1:0] model_pack();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CARS; i++) v[10*i +: 10] = 10'(m_x[i]);
        return v;
    endfunction

    // Frame divider model. Pushes the expected positions when this edge starts a sweep.
    task automatic frame_model();
        if (!bus.i_Enable) begin
            m_cnt = 0;
        end else if (m_cnt == 1) begin
            m_cnt = 0;
            model_step(2 + int'(bus.i_Speed_Level));
            exp_q.push_back(model_pack());
        end else begin
            m_cnt++;
        end
    endtask

    // Driver: one VSync low pulse, followed by enough blanking for a sweep to finish.
    task automatic drive_frame();
        @(negedge clk) bus.i_VGA_VSync = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_VGA_VSync = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic issue_frame();
        frame_model();
        drive_frame();
    endtask

    // Monitor: checks the busy window length and pops the scoreboard on each frame-done pulse.
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (bus.o_Busy) begin
                busy_run++;
                busy_total++;
            end else if (busy_run != 0) begin
                check_int("busy_len", busy_run, NUM_CARS);
                busy_run = 0;
            end
            if (bus.o_Frame_Done) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL frame_done_unexpected actual=1 expected=0");
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("sweep_x", bus.o_Car_X, mon_exp);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int bt;
        int k;
        rst = 1'b1;
        bus.i_VGA_VSync   = 1'b1;
        bus.i_Enable      = 1'b1;
        bus.i_Speed_Level = 2'd1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_x", bus.o_Car_X, RESET_X);
        check("reset_y", bus.o_Car_Y, RESET_Y);
        check_int("reset_busy", int'(bus.o_Busy), 0);
        check_int("reset_done", int'(bus.o_Frame_Done), 0);
        check_int("reset_state", int'(bus.o_Dbg_State), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Only the second falling edge starts a sweep
        issue_frame();
        check("first_edge_no_move", bus.o_Car_X, RESET_X);
        check_int("first_edge_no_done", done_count, 0);
        issue_frame();
        check("sweep1_x", bus.o_Car_X, SWEEP1_X);
        check_int("sweep1_done", done_count, 1);

        // Long run at step 3, hitting every wrap boundary exactly
        for (int s = 2; s <= 205; s++) begin
            issue_frame();
            issue_frame();
            case (s)
                53:  check_int("car1_at_1", car_x(1), 1);
                54:  check_int("car1_wrap_left", car_x(1), 608);
                96:  check_int("car2_at_max", car_x(2), 608);
                97:  check_int("car2_wrap_right", car_x(2), 0);
                160: check_int("car3_at_0", car_x(3), 0);
                161: check_int("car3_wrap_left_from_0", car_x(3), 608);
                202: check_int("car0_at_606", car_x(0), 606);
                203: check_int("car0_wrap_right", car_x(0), 0);
                default: ;
            endcase
        end
        check_int("long_run_sweeps", done_count, 205);

        // Frozen: six edges with no motion
        bus.i_Enable = 1'b0;
        bt = busy_total;
        repeat (6) issue_frame();
        check("frozen_x", bus.o_Car_X, model_pack());
        check_int("frozen_busy_cycles", busy_total, bt);
        check_int("frozen_sweeps", done_count, 205);
        bus.i_Enable = 1'b1;
        issue_frame();
        check_int("reenable_first_edge", done_count, 205);
        issue_frame();
        check_int("reenable_second_edge", done_count, 206);

        // Speed change during a sweep takes effect only on the next sweep
        bus.i_Speed_Level = 2'd1;
        issue_frame();
        frame_model();
        @(negedge clk) bus.i_VGA_VSync = 1'b0;
        k = 0;
        while (!bus.o_Busy && k < 6) begin
            @(negedge clk);
            k++;
        end
        check_int("speed_change_busy_seen", int'(bus.o_Busy), 1);
        bus.i_Speed_Level = 2'd3;
        @(negedge clk) bus.i_VGA_VSync = 1'b1;
        repeat (10) @(negedge clk);
        check_int("speed_change_sweep", done_count, 207);
        issue_frame();
        issue_frame();
        check_int("speed5_sweep", done_count, 208);

        // Reset two cycles into a sweep aborts it and restores the start positions
        bus.i_Speed_Level = 2'd1;
        issue_frame();
        @(negedge clk) bus.i_VGA_VSync = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_x", bus.o_Car_X, RESET_X);
        check_int("abort_busy", int'(bus.o_Busy), 0);
        check_int("abort_done", int'(bus.o_Frame_Done), 0);
        model_reset();
        exp_q.delete();
        @(negedge clk) bus.i_VGA_VSync = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_int("abort_no_done_pulse", done_count, 208);
        issue_frame();
        issue_frame();
        check_int("after_abort_sweep", done_count, 209);
        check("after_abort_x", bus.o_Car_X, SWEEP1_X);

        repeat (5) @(negedge clk);
        check_int("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
